// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters, one transaction at a time.
// Define ARB_FAIR_EN to alternate grants under contention instead of fixed data-over-fetch priority.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_valid,
  output logic [DW-1:0]   if_rdata,
  output logic            if_stall,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_wstrb,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_valid,
  output logic [DW-1:0]   d_rdata,
  output logic            d_stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            bus_err
);
  localparam int SW = DW / 8;
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;
  state_t state_q, state_d;
  logic own_q, own_d;
  logic drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mem_req_q, mem_req_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic if_valid_q, if_valid_d, d_valid_q, d_valid_d, bus_err_q, bus_err_d;
  logic d_elig, if_elig, pick_d, tmo, fin, err, drop;
`ifdef ARB_FAIR_EN
  logic last_q, last_d;
`endif
  // A requester whose valid is showing this cycle is still holding req from the finished access
  assign d_elig = d_req & ~d_valid_q;
  assign if_elig = if_req & ~if_valid_q & ~flush;
`ifdef ARB_FAIR_EN
  assign pick_d = d_elig & (~if_elig | ~last_q);
`else
  assign pick_d = d_elig;
`endif
  assign tmo = (TIMEOUT_CYCLES != 0) && (cnt_q == T_LAST);
  assign drop = drop_q | flush;
  always_comb begin
    state_d = state_q;
    own_d = own_q;
    drop_d = drop_q | (~own_q & flush);
    cnt_d = cnt_q + 1'b1;
    mem_req_d = mem_req_q;
    addr_d = addr_q;
    we_d = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    if_valid_d = 1'b0;
    d_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d = d_rdata_q;
    bus_err_d = 1'b0;
    fin = 1'b0;
    err = 1'b0;
`ifdef ARB_FAIR_EN
    last_d = last_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        drop_d = 1'b0;
        if (d_elig | if_elig) begin
          state_d = ISSUE;
          own_d = pick_d;
          mem_req_d = 1'b1;
          addr_d = pick_d ? d_addr : if_addr;
          we_d = pick_d & d_we;
          wdata_d = pick_d ? d_wdata : '0;
          wstrb_d = pick_d ? d_wstrb : '0;
`ifdef ARB_FAIR_EN
          last_d = pick_d;
`endif
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          state_d = we_q ? IDLE : WAIT_RSP;
          mem_req_d = 1'b0;
          cnt_d = '0;
          d_valid_d = we_q;
        end
        err = ~mem_gnt & tmo;
        fin = err;
      end
      WAIT_RSP: begin
        err = ~mem_rvalid & tmo;
        fin = mem_rvalid | err;
      end
      default: state_d = IDLE;
    endcase
    // Response or timeout abort; a flushed fetch completes silently
    if (fin) begin
      state_d = IDLE;
      mem_req_d = 1'b0;
      bus_err_d = err;
      if (own_q) begin
        d_valid_d = 1'b1;
        d_rdata_d = err ? '0 : mem_rdata;
      end else if (~drop) begin
        if_valid_d = 1'b1;
        if_rdata_d = err ? '0 : mem_rdata;
      end
    end
    if (state_d == IDLE) drop_d = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      own_q <= 1'b0;
      drop_q <= 1'b0;
      cnt_q <= '0;
      mem_req_q <= 1'b0;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      if_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q <= '0;
      bus_err_q <= 1'b0;
`ifdef ARB_FAIR_EN
      last_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      own_q <= own_d;
      drop_q <= drop_d;
      cnt_q <= cnt_d;
      mem_req_q <= mem_req_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      if_valid_q <= if_valid_d;
      d_valid_q <= d_valid_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q <= d_rdata_d;
      bus_err_q <= bus_err_d;
`ifdef ARB_FAIR_EN
      last_q <= last_d;
`endif
    end
  end
  assign mem_req = mem_req_q;
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign if_valid = if_valid_q;
  assign if_rdata = if_rdata_q;
  assign d_valid = d_valid_q;
  assign d_rdata = d_rdata_q;
  assign bus_err = bus_err_q;
  assign if_stall = if_req & ~if_valid_q;
  assign d_stall = d_req & ~d_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized transactions checked against a cycle-count reference model.
module tb_mem_port_arbiter;
  localparam int T = 8;
  logic clk = 1'b0;
  logic reset, flush, if_req, d_req, d_we, mem_gnt, mem_rvalid;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0] d_wstrb;
  logic if_valid, if_stall, d_valid, d_stall, mem_req, mem_we, bus_err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  int checks = 0;
  int passed = 0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata = '0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask
  task automatic idle_inputs();
    if_req = 1'b0; d_req = 1'b0; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    d_we = 1'b0; d_wstrb = '0; if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
  endtask
  task automatic chk_zero(input string tag);
    chk1({tag, ".mem_req"}, mem_req, 1'b0);
    chk1({tag, ".mem_we"}, mem_we, 1'b0);
    chk({tag, ".mem_addr"}, mem_addr, 32'h0);
    chk({tag, ".mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, ".mem_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
    chk1({tag, ".if_valid"}, if_valid, 1'b0);
    chk1({tag, ".d_valid"}, d_valid, 1'b0);
    chk({tag, ".if_rdata"}, if_rdata, 32'h0);
    chk({tag, ".d_rdata"}, d_rdata, 32'h0);
    chk1({tag, ".bus_err"}, bus_err, 1'b0);
  endtask
  // One transaction; g = extra cycles before mem_gnt, r = extra cycles before mem_rvalid (>= T never arrives)
  task automatic txn(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input int g, input int r, input logic [31:0] rd,
                     input int flush_at, input string tag);
    int exp_cyc, issue_last;
    bit err, dropped, req_on, fin_if, fin_d;
    logic [31:0] vdata;
    if (g >= T) begin exp_cyc = 1 + T; err = 1'b1; end
    else if (we) begin exp_cyc = g + 2; err = 1'b0; end
    else if (r >= T) begin exp_cyc = g + 2 + T; err = 1'b1; end
    else begin exp_cyc = g + r + 3; err = 1'b0; end
    issue_last = 1 + (g >= T ? T - 1 : g);
    dropped = !is_d && flush_at >= 1 && flush_at < exp_cyc;
    vdata = err ? 32'h0 : rd;
    for (int c = 0; c <= exp_cyc + 1; c++) begin
      @(negedge clk);
      req_on = c >= 1 && c <= issue_last;
      fin_if = c == exp_cyc && !is_d && !dropped;
      fin_d = c == exp_cyc && is_d;
      chk1({tag, ".mem_req"}, mem_req, req_on);
      if (req_on) begin
        chk({tag, ".mem_addr"}, mem_addr, addr);
        chk1({tag, ".mem_we"}, mem_we, we);
        chk({tag, ".mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, is_d ? wstrb : 4'h0});
        if (we) chk({tag, ".mem_wdata"}, mem_wdata, wdata);
      end
      chk1({tag, ".if_valid"}, if_valid, fin_if);
      chk1({tag, ".d_valid"}, d_valid, fin_d);
      chk1({tag, ".bus_err"}, bus_err, c == exp_cyc && err);
      if (c == exp_cyc) begin
        if (is_d && (!we || err)) exp_d_rdata = vdata;
        if (fin_if) exp_if_rdata = vdata;
        chk({tag, ".if_rdata"}, if_rdata, exp_if_rdata);
        chk({tag, ".d_rdata"}, d_rdata, exp_d_rdata);
      end
      if_req = !is_d && (dropped ? c < exp_cyc : c <= exp_cyc);
      d_req = is_d && c <= exp_cyc;
      if_addr = is_d ? $urandom : addr;
      d_addr = is_d ? addr : $urandom;
      d_we = we;
      d_wdata = wdata;
      d_wstrb = wstrb;
      mem_gnt = g < T && c == 1 + g;
      mem_rvalid = !we && g < T && r < T && c == g + 2 + r;
      mem_rdata = mem_rvalid ? rd : $urandom;
      flush = c == flush_at;
      #1;
      chk1({tag, ".if_stall"}, if_stall, if_req && !fin_if);
      chk1({tag, ".d_stall"}, d_stall, d_req && !fin_d);
    end
  endtask
  initial begin
    int g, r, ec, fa;
    bit is_d, we;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    // Contention: data served first, fetch follows from the data valid cycle
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      chk1("cont.mem_req", mem_req, c == 1 || c == 4);
      if (c == 1) chk("cont.addr_d", mem_addr, 32'h200);
      if (c == 4) chk("cont.addr_if", mem_addr, 32'h100);
      chk1("cont.d_valid", d_valid, c == 3);
      chk1("cont.if_valid", if_valid, c == 6);
      if (c == 3) chk("cont.d_rdata", d_rdata, 32'h12345678);
      if (c == 6) chk("cont.if_rdata", if_rdata, 32'h00500093);
      d_req = c <= 3; d_we = 1'b0; d_addr = 32'h200; d_wstrb = 4'hF;
      if_req = c <= 6; if_addr = 32'h100;
      mem_gnt = c == 1 || c == 4;
      mem_rvalid = c == 2 || c == 5;
      mem_rdata = c == 2 ? 32'h12345678 : c == 5 ? 32'h00500093 : $urandom;
      #1;
      chk1("cont.if_stall", if_stall, c <= 5);
      chk1("cont.d_stall", d_stall, c <= 2);
    end
    exp_d_rdata = 32'h12345678;
    exp_if_rdata = 32'h00500093;
    txn(0, 0, 32'h100, 0, 4'h0, 0, 0, 32'h00500093, -1, "fetch");
    txn(1, 0, 32'h200, 0, 4'hF, 0, 0, 32'h12345678, -1, "dread");
    txn(1, 1, 32'h200, 32'hDEADBEEF, 4'hF, 3, 0, 0, -1, "store");
    txn(0, 0, 32'h40, 0, 4'h0, 0, 1, 32'hCAFEF00D, 2, "flush");
    txn(0, 0, 32'h80, 0, 4'h0, 0, 0, 32'h00100073, -1, "after_flush");
    txn(1, 0, 32'h204, 0, 4'hF, 0, 0, 32'h5A5A5A5A, 1, "flush_data");
    txn(0, 0, 32'h300, 0, 4'h0, T, 0, 32'h11111111, -1, "tmo_issue");
    txn(1, 0, 32'h304, 0, 4'h3, 1, T, 32'h22222222, -1, "tmo_wait");
    txn(1, 1, 32'h308, 32'h33333333, 4'h1, T + 2, 0, 0, -1, "tmo_store");
    for (int i = 0; i < 16; i++) begin
      is_d = 1'($urandom_range(0, 1));
      we = is_d && 1'($urandom_range(0, 1));
      g = ($urandom_range(0, 5) == 0) ? T : int'($urandom_range(0, 3));
      r = ($urandom_range(0, 5) == 0) ? T : int'($urandom_range(0, 3));
      ec = g >= T ? T + 1 : we ? g + 2 : g + 2 + (r >= T ? T : r + 1);
      fa = -1;
      if ($urandom_range(0, 2) == 0) fa = is_d ? int'($urandom_range(0, ec)) : int'($urandom_range(1, ec - 2));
      txn(is_d, we, $urandom, $urandom, 4'($urandom), g, r, $urandom, fa, "rand");
    end
    // Reset while waiting for a read response; the late response must be ignored
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h300;
    @(negedge clk);
    chk1("rst.mem_req", mem_req, 1'b1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; reset = 1'b1; if_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk_zero("rst_mid");
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk_zero("rst_late");
    exp_if_rdata = '0;
    exp_d_rdata = '0;
    txn(0, 0, 32'h400, 0, 4'h0, 0, 0, 32'h00000013, -1, "post_rst");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
